// File: rtl/mem_arbiter_rr_pkg.sv
// mem_arbiter_rr_pkg
//   Shared types for the CPU/RAM arbiter slice.
//   - ramstate_t  : handshake state reported by the RAM model
//   - word_t      : native 32-bit machine word
//   - arb_state_t : arbiter FSM states
//   - arb_class_t : request class of the granted source (instruction or data)
//   - ptr_width() : bit width needed to index N CPUs (never less than 1)
package mem_arbiter_rr_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef logic [31:0] word_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } arb_state_t;

    typedef enum logic {
        ACLS_I = 1'b0,
        ACLS_D = 1'b1
    } arb_class_t;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_if.sv
// mem_arbiter_rr_if
//   Bundles the per-CPU cache request/response lanes and the single RAM port.
//   Modports:
//   - slave  : the arbiter (consumes requests and ramload/ramstate, drives
//              waits, load lanes and the RAM command)
//   - master : the environment (caches plus RAM model)
//   Parameters: CPUS cache pairs, AW address width, DW data width.
interface mem_arbiter_rr_if #(
    parameter int CPUS = 2,
    parameter int AW   = 32,
    parameter int DW   = 32
);
    import mem_arbiter_rr_pkg::*;

    // cache side
    logic [CPUS-1:0]         iREN;
    logic [CPUS-1:0][AW-1:0] iaddr;
    logic [CPUS-1:0]         dREN;
    logic [CPUS-1:0]         dWEN;
    logic [CPUS-1:0][AW-1:0] daddr;
    logic [CPUS-1:0][DW-1:0] dstore;
    logic [CPUS-1:0]         iwait;
    logic [CPUS-1:0]         dwait;
    logic [CPUS-1:0][DW-1:0] iload;
    logic [CPUS-1:0][DW-1:0] dload;

    // RAM side
    logic                    ramREN;
    logic                    ramWEN;
    logic [AW-1:0]           ramaddr;
    logic [DW-1:0]           ramstore;
    logic [DW-1:0]           ramload;
    ramstate_t               ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// rr_picker
//   Circular first-set-bit finder used for round-robin selection.
//   Ports:
//   - req   : one request bit per CPU
//   - ptr   : CPU index where the search starts
//   - valid : at least one request bit is set
//   - idx   : first set bit at or after ptr, wrapping past N-1 back to 0
module rr_picker
    import mem_arbiter_rr_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]              req,
    input  logic [ptr_width(N)-1:0]   ptr,
    output logic                      valid,
    output logic [ptr_width(N)-1:0]   idx
);
    localparam int PW = ptr_width(N);

    logic [PW:0]   sum;
    logic [PW-1:0] cand;

    // Walk the offsets from farthest to nearest so the nearest requester
    // at or after ptr is the last one written and therefore wins.
    always_comb begin
        valid = 1'b0;
        idx   = ptr;
        sum   = '0;
        cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (PW + 1)'(k);
            if (sum >= (PW + 1)'(N)) begin
                sum = sum - (PW + 1)'(N);
            end
            cand = sum[PW-1:0];
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr
//   Registered round-robin arbiter between CPUS icache/dcache pairs and one
//   single-ported RAM. Data requests beat instruction fetches; inside each
//   class a rotating pointer gives fairness. A grant is held for the whole
//   RAM transaction and ramload is broadcast to every load lane.
//   Ports:
//   - CLK  : clock, rising edge
//   - nRST : asynchronous active-low reset
//   - bus  : mem_arbiter_rr_if slave modport (cache lanes + RAM port)
module mem_arbiter_rr
    import mem_arbiter_rr_pkg::*;
#(
    parameter int CPUS = 2,
    parameter int AW   = 32,
    parameter int DW   = 32
) (
    input  logic            CLK,
    input  logic            nRST,
    mem_arbiter_rr_if.slave bus
);
    localparam int PW = ptr_width(CPUS);

    arb_state_t      state, next_state;
    arb_class_t      src_cls;
    logic [PW-1:0]   src_cpu;
    logic [PW-1:0]   dptr, iptr;

    logic [CPUS-1:0] dreq;
    logic            d_valid, i_valid;
    logic [PW-1:0]   d_idx, i_idx;
    logic            live;
    logic            done;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] cpu);
        return (cpu == PW'(CPUS - 1)) ? '0 : cpu + 1'b1;
    endfunction

    assign dreq = bus.dREN | bus.dWEN;

    rr_picker #(.N(CPUS)) u_dpick (
        .req   (dreq),
        .ptr   (dptr),
        .valid (d_valid),
        .idx   (d_idx)
    );

    rr_picker #(.N(CPUS)) u_ipick (
        .req   (bus.iREN),
        .ptr   (iptr),
        .valid (i_valid),
        .idx   (i_idx)
    );

    // The granted source is still asking; if it lets go mid-transaction the
    // access is abandoned without a wait pulse.
    always_comb begin
        live = 1'b0;
        if (src_cls == ACLS_D) begin
            live = dreq[src_cpu];
        end else begin
            live = bus.iREN[src_cpu];
        end
    end

    assign done = (state == SERVE) && live && (bus.ramstate == ACCESS);

    // State, grant and fairness pointers. A pointer only advances on a
    // completed access, so an aborted source keeps its turn.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            src_cls <= ACLS_I;
            src_cpu <= '0;
            dptr    <= '0;
            iptr    <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state == SERVE) begin
                src_cls <= d_valid ? ACLS_D : ACLS_I;
                src_cpu <= d_valid ? d_idx : i_idx;
            end
            if (done) begin
                if (src_cls == ACLS_D) begin
                    dptr <= wrap_inc(src_cpu);
                end else begin
                    iptr <= wrap_inc(src_cpu);
                end
            end
        end
    end

    // Next state: leave SERVE on completion or on a withdrawn request;
    // ERROR/BUSY/FREE simply keep retrying.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:  if (d_valid || i_valid) next_state = SERVE;
            SERVE: if (!live || bus.ramstate == ACCESS) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // RAM command follows the granted source's live inputs; a write wins
    // over a read when a data port raises both.
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = {AW{1'b0}};
        bus.ramstore = {DW{1'b0}};
        bus.iwait    = '1;
        bus.dwait    = '1;
        if (state == SERVE) begin
            if (src_cls == ACLS_D) begin
                bus.ramaddr = bus.daddr[src_cpu];
                if (bus.dWEN[src_cpu]) begin
                    bus.ramWEN   = 1'b1;
                    bus.ramstore = bus.dstore[src_cpu];
                end else begin
                    bus.ramREN = bus.dREN[src_cpu];
                end
                if (done) bus.dwait[src_cpu] = 1'b0;
            end else begin
                bus.ramaddr = bus.iaddr[src_cpu];
                bus.ramREN  = bus.iREN[src_cpu];
                if (done) bus.iwait[src_cpu] = 1'b0;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < CPUS; k++) begin
            bus.iload[k] = bus.ramload;
            bus.dload[k] = bus.ramload;
        end
    end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr
//   Directed scenarios on a 2-CPU arbiter plus a 4-CPU round-robin scenario,
//   followed by randomized traffic compared against a transaction-level
//   reference model of the arbitration rules.
module tb_mem_arbiter_rr;
    import mem_arbiter_rr_pkg::*;

    logic clk;
    logic rst_n;
    int   n_pass  = 0;
    int   n_total = 0;

    mem_arbiter_rr_if #(.CPUS(2), .AW(32), .DW(32)) bus  ();
    mem_arbiter_rr_if #(.CPUS(4), .AW(32), .DW(32)) bus4 ();

    mem_arbiter_rr #(.CPUS(2), .AW(32), .DW(32)) dut (
        .CLK  (clk),
        .nRST (rst_n),
        .bus  (bus.slave)
    );

    mem_arbiter_rr #(.CPUS(4), .AW(32), .DW(32)) dut4 (
        .CLK  (clk),
        .nRST (rst_n),
        .bus  (bus4.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs are driven just after a falling edge, outputs sampled 1 time unit later.
    task automatic clear_inputs();
        bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0;
        bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
        bus.ramload = '0; bus.ramstate = FREE;
        bus4.iREN = '0; bus4.dREN = '0; bus4.dWEN = '0;
        bus4.iaddr = '0; bus4.daddr = '0; bus4.dstore = '0;
        bus4.ramload = '0; bus4.ramstate = FREE;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        bus.dREN = 2'b01;
        bus.iREN = 2'b10;
        #1;
        n_total++; if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0) $display("[TB] FAIL reset_enables got=%b%b exp=00", bus.ramREN, bus.ramWEN); else n_pass++;
        n_total++; if (bus.ramaddr !== 32'h0 || bus.ramstore !== 32'h0) $display("[TB] FAIL reset_bus got=%h/%h exp=0/0", bus.ramaddr, bus.ramstore); else n_pass++;
        n_total++; if (bus.iwait !== 2'b11 || bus.dwait !== 2'b11) $display("[TB] FAIL reset_waits got=%b/%b exp=11/11", bus.iwait, bus.dwait); else n_pass++;
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        @(negedge clk);
        bus.dREN = 2'b01; bus.daddr[0] = 32'h40; bus.ramstate = FREE;
        #1;
        n_total++; if (bus.ramREN !== 1'b0) $display("[TB] FAIL single_c0_ren got=%b exp=0", bus.ramREN); else n_pass++;
        @(negedge clk);
        bus.ramstate = BUSY;
        #1;
        n_total++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h40) $display("[TB] FAIL single_c1 got=%b/%h exp=1/00000040", bus.ramREN, bus.ramaddr); else n_pass++;
        n_total++; if (bus.dwait !== 2'b11) $display("[TB] FAIL single_c1_dwait got=%b exp=11", bus.dwait); else n_pass++;
        @(negedge clk);
        bus.ramstate = ACCESS; bus.ramload = 32'h1234_5678;
        #1;
        n_total++; if (bus.dwait !== 2'b10) $display("[TB] FAIL single_c2_dwait got=%b exp=10", bus.dwait); else n_pass++;
        n_total++; if (bus.dload[0] !== 32'h1234_5678 || bus.iload[1] !== 32'h1234_5678) $display("[TB] FAIL single_load got=%h/%h exp=12345678", bus.dload[0], bus.iload[1]); else n_pass++;
        @(negedge clk);
        clear_inputs();
        #1;
        n_total++; if (bus.dwait !== 2'b11 || bus.ramREN !== 1'b0) $display("[TB] FAIL single_c3 got=%b/%b exp=11/0", bus.dwait, bus.ramREN); else n_pass++;
    endtask

    task automatic test_priority();
        @(negedge clk);
        bus.iREN = 2'b01; bus.iaddr[0] = 32'h100;
        bus.dWEN = 2'b10; bus.daddr[1] = 32'h200; bus.dstore[1] = 32'hDEAD_BEEF;
        bus.ramstate = ACCESS;
        #1;
        n_total++; if (bus.ramWEN !== 1'b0 || bus.ramREN !== 1'b0) $display("[TB] FAIL prio_idle got=%b%b exp=00", bus.ramREN, bus.ramWEN); else n_pass++;
        @(negedge clk);
        #1;
        n_total++; if ({bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore} !== {1'b0, 1'b1, 32'h200, 32'hDEAD_BEEF}) $display("[TB] FAIL prio_write got=%b%b %h %h exp=01 00000200 deadbeef", bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore); else n_pass++;
        n_total++; if (bus.dwait !== 2'b01 || bus.iwait !== 2'b11) $display("[TB] FAIL prio_waits1 got=%b/%b exp=01/11", bus.dwait, bus.iwait); else n_pass++;
        @(negedge clk);
        bus.dWEN = 2'b00;
        #1;
        n_total++; if (bus.iwait !== 2'b11 || bus.ramREN !== 1'b0) $display("[TB] FAIL prio_bubble got=%b/%b exp=11/0", bus.iwait, bus.ramREN); else n_pass++;
        @(negedge clk);
        #1;
        n_total++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h100 || bus.iwait !== 2'b10) $display("[TB] FAIL prio_ifetch got=%b %h %b exp=1 00000100 10", bus.ramREN, bus.ramaddr, bus.iwait); else n_pass++;
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_dw;
        int         exp_cpu;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            if (t == 0) begin
                bus.dREN = 2'b11; bus.daddr[0] = 32'h10; bus.daddr[1] = 32'h14;
                bus.ramstate = ACCESS;
            end
            #1;
            n_total++; if (bus.ramREN !== 1'b0) $display("[TB] FAIL rr_bubble t=%0d got=%b exp=0", t, bus.ramREN); else n_pass++;
            @(negedge clk);
            #1;
            exp_cpu = t % 2;
            exp_dw  = (exp_cpu == 0) ? 2'b10 : 2'b01;
            n_total++; if (bus.ramaddr !== ((exp_cpu == 0) ? 32'h10 : 32'h14) || bus.dwait !== exp_dw) $display("[TB] FAIL rr_grant t=%0d got=%h/%b exp_cpu=%0d dwait=%b", t, bus.ramaddr, bus.dwait, exp_cpu, exp_dw); else n_pass++;
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_abort();
        @(negedge clk);
        bus.iREN = 2'b10; bus.iaddr[1] = 32'h300; bus.ramstate = BUSY;
        #1;
        n_total++; if (bus.ramREN !== 1'b0) $display("[TB] FAIL abort_idle got=%b exp=0", bus.ramREN); else n_pass++;
        @(negedge clk);
        #1;
        n_total++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h300 || bus.iwait !== 2'b11) $display("[TB] FAIL abort_serve got=%b %h %b exp=1 00000300 11", bus.ramREN, bus.ramaddr, bus.iwait); else n_pass++;
        @(negedge clk);
        bus.iREN = 2'b00; bus.ramstate = ACCESS;
        #1;
        n_total++; if (bus.ramREN !== 1'b0 || bus.iwait !== 2'b11) $display("[TB] FAIL abort_drop got=%b/%b exp=0/11", bus.ramREN, bus.iwait); else n_pass++;
        @(negedge clk);
        bus.iREN = 2'b11; bus.iaddr[0] = 32'h500;
        #1;
        n_total++; if (bus.ramREN !== 1'b0) $display("[TB] FAIL abort_back_idle got=%b exp=0", bus.ramREN); else n_pass++;
        @(negedge clk);
        #1;
        n_total++; if (bus.ramaddr !== 32'h300 || bus.iwait !== 2'b01) $display("[TB] FAIL abort_regrant got=%h/%b exp=00000300/01", bus.ramaddr, bus.iwait); else n_pass++;
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_error_retry();
        @(negedge clk);
        bus.dWEN = 2'b01; bus.daddr[0] = 32'h80; bus.dstore[0] = 32'hCAFE_F00D;
        bus.ramstate = ERROR;
        #1;
        n_total++; if (bus.ramWEN !== 1'b0) $display("[TB] FAIL err_idle got=%b exp=0", bus.ramWEN); else n_pass++;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            n_total++; if ({bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore, bus.dwait} !== {1'b0, 1'b1, 32'h80, 32'hCAFE_F00D, 2'b11}) $display("[TB] FAIL err_hold c=%0d got=%b%b %h %h %b", c, bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore, bus.dwait); else n_pass++;
        end
        @(negedge clk);
        bus.ramstate = ACCESS;
        #1;
        n_total++; if (bus.ramWEN !== 1'b1 || bus.dwait !== 2'b10) $display("[TB] FAIL err_access got=%b/%b exp=1/10", bus.ramWEN, bus.dwait); else n_pass++;
        @(negedge clk);
        clear_inputs();
        #1;
        n_total++; if (bus.ramWEN !== 1'b0 || bus.dwait !== 2'b11) $display("[TB] FAIL err_after got=%b/%b exp=0/11", bus.ramWEN, bus.dwait); else n_pass++;
    endtask

    // The data pointer sits at CPU1 on entry, so CPU0 winning afterwards
    // shows the pointer returned to 0.
    task automatic test_reset_mid();
        @(negedge clk);
        bus.dREN = 2'b01; bus.daddr[0] = 32'h40; bus.ramstate = BUSY;
        #1;
        @(negedge clk);
        #1;
        n_total++; if (bus.ramREN !== 1'b1) $display("[TB] FAIL rstmid_pre got=%b exp=1", bus.ramREN); else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_total++; if (bus.ramREN !== 1'b0 || bus.dwait !== 2'b11) $display("[TB] FAIL rstmid_drop got=%b/%b exp=0/11", bus.ramREN, bus.dwait); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        bus.dREN = 2'b11; bus.daddr[1] = 32'h44; bus.ramstate = ACCESS;
        #1;
        n_total++; if (bus.ramREN !== 1'b0) $display("[TB] FAIL rstmid_idle got=%b exp=0", bus.ramREN); else n_pass++;
        @(negedge clk);
        #1;
        n_total++; if (bus.ramaddr !== 32'h40 || bus.dwait !== 2'b10) $display("[TB] FAIL rstmid_ptr got=%h/%b exp=00000040/10", bus.ramaddr, bus.dwait); else n_pass++;
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_rr4();
        int order [5] = '{0, 1, 2, 3, 0};
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            if (t == 0) begin
                bus4.iREN = 4'hF; bus4.ramstate = ACCESS;
                for (int k = 0; k < 4; k++) bus4.iaddr[k] = 32'h1000 + 32'(4 * k);
            end
            #1;
            @(negedge clk);
            #1;
            n_total++; if (bus4.ramaddr !== 32'h1000 + 32'(4 * order[t]) || bus4.iwait !== ~(4'b0001 << order[t])) $display("[TB] FAIL rr4_grant t=%0d got=%h/%b exp_cpu=%0d", t, bus4.ramaddr, bus4.iwait, order[t]); else n_pass++;
        end
        @(negedge clk);
        clear_inputs();
    endtask

    // Reference model: one outstanding grant at a time, winners found by
    // scanning CPUs from the class pointer with modulo arithmetic.
    int        m_busy, m_d, m_cpu, m_dptr, m_iptr;

    task automatic test_random();
        logic        e_ren, e_wen, live;
        logic [31:0] e_addr, e_store, rl;
        logic [1:0]  e_iw, e_dw;
        int          found, c;
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        m_busy = 0; m_d = 0; m_cpu = 0; m_dptr = 0; m_iptr = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                bus.iREN = 2'($urandom);
                bus.dREN = 2'($urandom);
                bus.dWEN = 2'($urandom) & 2'($urandom);
            end
            for (int k = 0; k < 2; k++) begin
                bus.iaddr[k]  = $urandom;
                bus.daddr[k]  = $urandom;
                bus.dstore[k] = $urandom;
            end
            bus.ramstate = ($urandom_range(0, 1) == 1) ? ACCESS : ramstate_t'($urandom_range(0, 3));
            rl = $urandom;
            bus.ramload = rl;
            #1;
            e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0;
            e_iw = 2'b11; e_dw = 2'b11; live = 1'b0;
            if (m_busy != 0) begin
                if (m_d != 0) begin
                    live   = bus.dREN[m_cpu] | bus.dWEN[m_cpu];
                    e_addr = bus.daddr[m_cpu];
                    if (bus.dWEN[m_cpu]) begin
                        e_wen = 1'b1; e_store = bus.dstore[m_cpu];
                    end else if (bus.dREN[m_cpu]) begin
                        e_ren = 1'b1;
                    end
                    if (live && bus.ramstate == ACCESS) e_dw[m_cpu] = 1'b0;
                end else begin
                    live   = bus.iREN[m_cpu];
                    e_addr = bus.iaddr[m_cpu];
                    e_ren  = live;
                    if (live && bus.ramstate == ACCESS) e_iw[m_cpu] = 1'b0;
                end
            end
            n_total++; if ({bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore} !== {e_ren, e_wen, e_addr, e_store}) $display("[TB] FAIL rand_ram cyc=%0d got=%b%b %h %h exp=%b%b %h %h", cyc, bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore, e_ren, e_wen, e_addr, e_store); else n_pass++;
            n_total++; if ({bus.iwait, bus.dwait} !== {e_iw, e_dw}) $display("[TB] FAIL rand_wait cyc=%0d got=%b/%b exp=%b/%b", cyc, bus.iwait, bus.dwait, e_iw, e_dw); else n_pass++;
            n_total++; if ({bus.iload, bus.dload} !== {4{rl}}) $display("[TB] FAIL rand_load cyc=%0d got=%h exp=%h", cyc, bus.dload[1], rl); else n_pass++;
            // advance the model as the coming rising edge will
            if (m_busy == 0) begin
                found = 0;
                for (int k = 0; k < 2; k++) begin
                    c = (m_dptr + k) % 2;
                    if (found == 0 && (bus.dREN[c] | bus.dWEN[c])) begin found = 1; m_d = 1; m_cpu = c; end
                end
                for (int k = 0; k < 2; k++) begin
                    c = (m_iptr + k) % 2;
                    if (found == 0 && bus.iREN[c]) begin found = 1; m_d = 0; m_cpu = c; end
                end
                m_busy = found;
            end else if (!live) begin
                m_busy = 0;
            end else if (bus.ramstate == ACCESS) begin
                m_busy = 0;
                if (m_d != 0) m_dptr = (m_cpu + 1) % 2;
                else          m_iptr = (m_cpu + 1) % 2;
            end
        end
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_priority();
        test_round_robin();
        test_abort();
        test_error_retry();
        test_reset_mid();
        test_rr4();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- Parametrised N-CPU RAM arbiter. It sits between the per-CPU icache/dcache pairs and the single-ported RAM model.
- Replaces fixed-priority combinational arbitration with a registered grant FSM.
- Data requests have priority over instruction fetches. Round-robin fairness applies among CPUs within each class.
- Grant is held for the whole RAM transaction; ramload is broadcast to every requester.

Parameters:
- CPUS, 2, number of CPU cache pairs (>=1).
- AW, 32, address width.
- DW, 32, data width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- nRST  in  1  reset; one clock, asynchronous, active-low.
- iREN  in  CPUS  instruction read request per CPU.
- iaddr  in  CPUS x AW  instruction address per CPU.
- dREN  in  CPUS  data read request per CPU.
- dWEN  in  CPUS  data write request per CPU.
- daddr  in  CPUS x AW  data address per CPU.
- dstore  in  CPUS x DW  write data per CPU.
- iwait  out  CPUS  instruction stall; 0 for one cycle = read done.
- dwait  out  CPUS  data stall; 0 for one cycle = access done.
- iload  out  CPUS x DW  instruction read data (= ramload, all lanes).
- dload  out  CPUS x DW  data read data (= ramload, all lanes).
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  AW  RAM address.
- ramstore  out  DW  RAM write data.
- ramload  in  DW  RAM read data.
- ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR.

Behaviour:
- Reset (async, nRST=0): state=IDLE, dptr=0, iptr=0, grant cleared. Outputs: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, all iwait/dwait=1.
- States:
  - IDLE: pick a winner if any request is present. Data class (dREN|dWEN) beats instruction class. Within a class, pick the first requester at or after that class's pointer, modulo CPUS. Register src={class,cpu}; next=SERVE. With no request, stay IDLE and drive all RAM outputs to 0.
  - SERVE: drive RAM from the granted source's live inputs.
    - Data grant: ramaddr=daddr[cpu]. If dWEN[cpu]=1, ramWEN=1 and ramstore=dstore[cpu] (write wins if dREN and dWEN are both high). Otherwise ramREN=1.
    - Instruction grant: ramREN=1, ramaddr=iaddr[cpu].
- Completion: in a SERVE cycle with ramstate==ACCESS:
  - The granted wait output is 0 for that cycle only.
  - Next state is IDLE.
  - That class's pointer becomes cpu+1 mod CPUS.
- Latency: request seen in cycle 0; grant registered at end of cycle 0; RAM enables asserted from cycle 1; wait drops in the first SERVE cycle with ACCESS. Minimum is 2 cycles with zero-wait RAM. There is one IDLE bubble between transactions.
- Ungranted sources: wait stays 1 every cycle.
- Request withdrawn mid-SERVE (granted enable(s) low): abort, go to IDLE next cycle, no wait pulse, pointer unchanged.
- ramstate==ERROR or BUSY/FREE in SERVE: hold grant and keep enables asserted (retry); no timeout.
- Simultaneous requests: d beats i regardless of CPU. Among same-class requesters the pointer decides, e.g. CPUS=2, dptr=1, both dREN high -> CPU1 wins.
- A CPU with both an i and a d request gets d first; the i request is served in a later arbitration.
- Pointers wrap at CPUS-1 -> 0. With CPUS=1 the pointers stay 0.
- Reset asserted mid-SERVE: immediate return to reset values, RAM enables drop asynchronously.
- iload/dload: combinational copies of ramload on all lanes in all states.

Decomposition:
- cpu_types_pkg (existing): ramstate_t, word_t.
- Add to cpu_types_pkg: arb_state_t {IDLE, SERVE}, arb_class_t {ACLS_I, ACLS_D}.
- Sub-module rr_picker (param N): inputs req[N], ptr. Outputs valid and idx = first set bit at or after ptr, circular. Instantiate twice, once per class.

Test Plan:
1. Reset mid-transaction: CPU0 dREN=1, nRST low during SERVE -> ramREN=0, dwait=2'b11 same cycle; after release, state IDLE, pointers 0.
2. Single read: CPU0 dREN=1, daddr=0x40, RAM ACCESS on 2nd SERVE cycle -> ramREN=1 and ramaddr=0x40 from cycle 1; dwait[0]=0 only in cycle 2; dload[0]=ramload.
3. Priority: cycle 0 iREN[0]=1 and dWEN[1]=1, dstore[1]=0xDEADBEEF -> first grant ramWEN=1, ramstore=0xDEADBEEF; iwait[0] stays 1 until the second transaction's ACCESS.
4. Round-robin: both CPUs hold dREN continuously for 4 transactions -> grant order CPU0, CPU1, CPU0, CPU1; with CPUS=4 and all iREN -> order 0,1,2,3,0.
5. Abort: CPU1 iREN granted, dropped before ACCESS -> IDLE next cycle, no iwait pulse, iptr unchanged; next grant goes to CPU1 again if it re-requests first.
6. ERROR retry: ramstate=ERROR for 3 SERVE cycles, then ACCESS -> enables held steady throughout; single wait pulse on the ACCESS cycle.
